// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan serializer.
// Frame length depends on MUX_SCAN_PARITY_EN (see mux_scan_serializer).
package mux_scan_pkg;

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  // Start position of the select counter for a given bit order.
  function automatic logic [SEL_W-1:0] sel_start(input bit dir);
    return dir ? 3'd7 : 3'd0;
  endfunction

  // Step is applied modulo 8, so MSB-first uses +7 (i.e. -1).
  function automatic logic [SEL_W-1:0] sel_step(input bit dir);
    return dir ? 3'd7 : 3'd1;
  endfunction

endpackage

// File: rtl/mux_8x1.sv
// Purely combinational 8:1 bit selector.
module mux_8x1
  import mux_scan_pkg::*;
(
  input  logic [DATA_W-1:0] in,
  input  logic [SEL_W-1:0]  sel,
  output logic              out
);

  assign out = in[sel];

endmodule

// File: rtl/mux_scan_serializer.sv
// Byte-to-bit serializer: holds an accepted byte and scans it out through an 8:1 mux.
// Optional MUX_SCAN_PARITY_EN appends an even-parity beat after the 8 data beats.
module mux_scan_serializer
  import mux_scan_pkg::*;
#(
  parameter int unsigned DIR        = 0,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ser_out,
  output logic       ser_valid,
  input  logic       ser_ready,
  output logic       ser_first,
  output logic       ser_last,
  output logic       busy
);

  localparam logic [SEL_W-1:0] SEL_START = sel_start(DIR != 0);
  localparam logic [SEL_W-1:0] SEL_STEP  = sel_step(DIR != 0);
  localparam logic [3:0]       LAST_DATA = 4'd7;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_hold;
  logic [SEL_W-1:0]  r_sel;
  logic [3:0]        r_cnt;
  logic              w_bit;
  logic              w_accept;
  logic              w_xfer;
  logic              w_last_data;
  logic              w_frame_end;

  mux_8x1 u_mux (
    .in  (r_hold),
    .sel (r_sel),
    .out (w_bit)
  );

  assign w_accept    = (r_state == IDLE) && in_valid;
  assign w_xfer      = ser_valid && ser_ready;
  assign w_last_data = (r_state == SHIFT) && (r_cnt == LAST_DATA);
`ifdef MUX_SCAN_PARITY_EN
  assign w_frame_end = w_xfer && (r_state == PAR);
`else
  assign w_frame_end = w_xfer && w_last_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) w_state_nxt = SHIFT;
      end
      SHIFT: begin
`ifdef MUX_SCAN_PARITY_EN
        if (w_xfer && w_last_data) w_state_nxt = PAR;
`else
        if (w_xfer && w_last_data) w_state_nxt = IDLE;
`endif
      end
      PAR: begin
        if (w_xfer) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // After the last data beat the modulo-8 step lands back on SEL_START,
  // so the parity beat needs no explicit select reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
      r_sel  <= SEL_START;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_hold <= in_data;
      r_sel  <= SEL_START;
      r_cnt  <= '0;
    end else if (w_frame_end) begin
      r_sel  <= SEL_START;
      r_cnt  <= '0;
    end else if (w_xfer) begin
      r_sel  <= r_sel + SEL_STEP;
      r_cnt  <= r_cnt + 4'd1;
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_out   = IDLE_LEVEL;
    ser_first = 1'b0;
    ser_last  = 1'b0;
    busy      = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = w_bit;
        ser_first = (r_cnt == '0);
`ifdef MUX_SCAN_PARITY_EN
        ser_last  = 1'b0;
`else
        ser_last  = w_last_data;
`endif
      end
`ifdef MUX_SCAN_PARITY_EN
      PAR: begin
        ser_valid = 1'b1;
        ser_out   = ^r_hold;
        ser_last  = 1'b1;
      end
`endif
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Self-checking bench: LSB-first and MSB-first instances share stimulus and are
// compared every cycle against a bit-index model; frame literals pin the model.
module tb_mux_scan_serializer;

`ifdef MUX_SCAN_PARITY_EN
  localparam int N = 9;
`else
  localparam int N = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       ser_ready = 1'b1;
  logic [1:0] in_ready_v, ser_out_v, ser_valid_v, ser_first_v, ser_last_v, busy_v;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mux_scan_serializer #(.DIR(0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_v[0]), .ser_out(ser_out_v[0]), .ser_valid(ser_valid_v[0]),
    .ser_ready(ser_ready), .ser_first(ser_first_v[0]), .ser_last(ser_last_v[0]),
    .busy(busy_v[0])
  );

  mux_scan_serializer #(.DIR(1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_v[1]), .ser_out(ser_out_v[1]), .ser_valid(ser_valid_v[1]),
    .ser_ready(ser_ready), .ser_first(ser_first_v[1]), .ser_last(ser_last_v[1]),
    .busy(busy_v[1])
  );

  // Model: a frame is "word + index of the beat currently offered".
  logic       m_busy = 1'b0;
  logic [7:0] m_word = 8'h00;
  int         m_k = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_k    <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_word <= in_data;
        m_k    <= 0;
      end
    end else if (ser_ready) begin
      if (m_k == N - 1) begin
        m_busy <= 1'b0;
        m_k    <= 0;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  function automatic logic exp_bit(input int dir, input logic [7:0] w, input int k);
    if (k >= 8) return ^w;
    return (dir != 0) ? w[7 - k] : w[k];
  endfunction

  logic [8:0] acc [2];
  logic [8:0] fq0[$];
  logic [8:0] fq1[$];
  logic [5:0] c_exp, c_act;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      c_exp = {!m_busy, m_busy, m_busy, m_busy ? exp_bit(d, m_word, m_k) : 1'b0,
               m_busy && (m_k == 0), m_busy && (m_k == N - 1)};
      c_act = {in_ready_v[d], busy_v[d], ser_valid_v[d], ser_out_v[d],
               ser_first_v[d], ser_last_v[d]};
      compared++;
      if (c_act !== c_exp) begin
        mismatched++;
        $display("FAIL cycle_outputs dut%0d t=%0t {in_ready,busy,valid,out,first,last} got=%b want=%b",
                 d, $time, c_act, c_exp);
      end
      if (ser_valid_v[d] && ser_ready) begin
        acc[d] = ser_first_v[d] ? {8'h00, ser_out_v[d]} : {acc[d][7:0], ser_out_v[d]};
        if (ser_last_v[d]) begin
          if (d == 0) fq0.push_back(acc[d]);
          else        fq1.push_back(acc[d]);
        end
      end
    end
  end

  // Emission order packed first-beat-in-MSB; parity beat (if any) in bit 0.
  function automatic logic [8:0] mk(input logic [7:0] seq, input logic par);
`ifdef MUX_SCAN_PARITY_EN
    return {seq, par};
`else
    return {1'b0, seq} | {8'h00, 1'b0 & par};
`endif
  endfunction

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_frame(input string name, input int d, input logic [8:0] exp);
    logic [8:0] f;
    int sz;
    sz = (d == 0) ? fq0.size() : fq1.size();
    if (sz == 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s dut%0d: got no frame want %h", name, d, exp);
    end else begin
      f = (d == 0) ? fq0.pop_front() : fq1.pop_front();
      chk($sformatf("%s dut%0d", name, d), f, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (m_busy && t < 60) begin
      tick();
      t++;
    end
    if (m_busy) begin
      compared++;
      mismatched++;
      $display("FAIL %s: timeout got busy want idle", name);
    end
  endtask

  task automatic wait_k(input string name, input int k);
    int t = 0;
    while (!(m_busy && m_k == k) && t < 60) begin
      tick();
      t++;
    end
    if (!(m_busy && m_k == k)) begin
      compared++;
      mismatched++;
      $display("FAIL %s: timeout got beat %0d want %0d", name, m_k, k);
    end
  endtask

  task automatic load(input logic [7:0] d, input bit hold_valid);
    wait_idle("load_wait");
    in_data  = d;
    in_valid = 1'b1;
    tick();
    if (!hold_valid) in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_in_ready dut%0d", d), {8'h00, in_ready_v[d]}, 9'd1);
      chk($sformatf("reset_valid dut%0d", d), {8'h00, ser_valid_v[d]}, 9'd0);
      chk($sformatf("reset_out dut%0d", d), {8'h00, ser_out_v[d]}, 9'd0);
      chk($sformatf("reset_busy dut%0d", d), {8'h00, busy_v[d]}, 9'd0);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();

    // LSB/MSB order on a palindrome byte, then on a one-hot byte
    fq0.delete(); fq1.delete();
    load(8'hA5, 1'b0);
    wait_idle("a5");
    chk("a5_in_ready_after", {8'h00, in_ready_v[0]}, 9'd1);
    chk_frame("a5_frame", 0, mk(8'hA5, 1'b0));
    chk_frame("a5_frame", 1, mk(8'hA5, 1'b0));
    load(8'h01, 1'b0);
    wait_idle("01");
    chk_frame("01_frame", 0, mk(8'h80, 1'b1));
    chk_frame("01_frame", 1, mk(8'h01, 1'b1));

    // Backpressure while beat 3 is offered
    load(8'h3C, 1'b0);
    wait_k("bp", 2);
    ser_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_out dut0", {8'h00, ser_out_v[0]}, 9'd1);
      chk("bp_hold_out dut1", {8'h00, ser_out_v[1]}, 9'd1);
    end
    ser_ready = 1'b1;
    wait_idle("bp");
    chk_frame("bp_frame", 0, mk(8'h3C, 1'b0));
    chk_frame("bp_frame", 1, mk(8'h3C, 1'b0));

    // Reset in the middle of a frame
    load(8'hFF, 1'b0);
    wait_k("rst_mid", 4);
    rst = 1'b1;
    #2;
    chk("rst_mid_valid dut0", {8'h00, ser_valid_v[0]}, 9'd0);
    chk("rst_mid_out dut1", {8'h00, ser_out_v[1]}, 9'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_mid_in_ready dut0", {8'h00, in_ready_v[0]}, 9'd1);
    load(8'h00, 1'b0);
    wait_idle("after_rst");
    chk_frame("after_rst_frame", 0, mk(8'h00, 1'b0));
    chk_frame("after_rst_frame", 1, mk(8'h00, 1'b0));
    chk("no_partial_frame", 9'(fq0.size() + fq1.size()), 9'd0);

    // Back-to-back words with in_valid held; data change mid-frame is ignored
    load(8'h0F, 1'b1);
    in_data = 8'hF0;
    wait_idle("b2b_first");
    tick();
    in_valid = 1'b0;
    chk("b2b_second_accepted dut0", {8'h00, busy_v[0]}, 9'd1);
    wait_idle("b2b_second");
    chk_frame("b2b_frame1", 0, mk(8'hF0, 1'b0));
    chk_frame("b2b_frame2", 0, mk(8'h0F, 1'b0));
    chk_frame("b2b_frame1", 1, mk(8'h0F, 1'b0));
    chk_frame("b2b_frame2", 1, mk(8'hF0, 1'b0));

`ifdef MUX_SCAN_PARITY_EN
    load(8'h07, 1'b0);
    wait_idle("par07");
    chk_frame("par07_frame", 0, mk(8'hE0, 1'b1));
    chk_frame("par07_frame", 1, mk(8'h07, 1'b1));
    load(8'hA5, 1'b0);
    wait_idle("para5");
    chk_frame("para5_frame", 0, mk(8'hA5, 1'b0));
    chk_frame("para5_frame", 1, mk(8'hA5, 1'b0));
`endif

    // Random traffic, backpressure and occasional resets
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 2) == 0);
      in_data   = 8'($urandom);
      ser_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    ser_ready = 1'b1;
    wait_idle("random_drain");
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
